mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Byte-serial controller for the single 8-bit RAM port, shared between instruction fetch and the memory unit's load/store path. Arbitrates the two requesters round-robin and sequences 1/2/4-byte accesses as consecutive byte transfers. Assembles little-endian read data with sign or zero extension. Aborts in-flight reads on pipeline flush; a store, once started, always completes.

## Interface
- No parameters.
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- flush_input  in  1  pipeline flush; aborts in-flight reads
- if_req  in  1  fetch request; held until if_done
- if_addr  in  32  fetch byte address
- if_done  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched word
- lsu_req  in  1  load/store request; held until lsu_done
- lsu_we  in  1  0 load, 1 store
- lsu_op  in  3  func3: [1:0] size 00 B / 01 H / 10 W; [2] unsigned (loads only)
- lsu_addr  in  32  byte address; no alignment required
- lsu_wdata  in  32  store data; low bytes used
- lsu_done  out  1  one-cycle pulse: load data valid or store finished
- lsu_rdata  out  32  extended load data
- mem_din  in  8  RAM read data; reflects the address driven one cycle earlier
- mem_dout  out  8  RAM write data
- mem_a  out  32  RAM address
- mem_wr  out  1  1 write, 0 read
- io_buffer_full  in  1  UART output buffer full

## Operation
- States: IDLE, READ, WRITE, DONE. Count register cnt[2:0]; byte total N = 1/2/4 from size. Fetch always uses N=4.
- IDLE: grant only from this state.
  - One requester high: grant it.
  - Both high: grant the one not granted last. last_grant resets to fetch, so the LSU wins the first tie.
  - Latch address, op, we and wdata. Go to READ or WRITE with cnt=0.
- READ, per cycle: mem_a=addr+cnt, mem_wr=0. Byte cnt−1 is sampled from mem_din into position (cnt−1)·8.
  - After byte N−1 is sampled: apply extension. Signed uses sign-extension from bit 8N−1; unsigned or word uses zero-fill. Go to DONE.
- WRITE, per cycle: mem_a=addr+cnt, mem_dout=wdata[8cnt+7:8cnt], mem_wr=1.
  - After byte N−1: go to DONE.
- DONE: pulse the granted requester's done for one cycle. rdata holds its value until the next grant. Requests seen in DONE are ignored; return to IDLE.
- Outside WRITE: mem_wr=0 and mem_dout=0. mem_a holds its last value.
- Address arithmetic wraps modulo 2^32.
- Flush:
  - In READ: return to IDLE at the next edge; no done pulse.
  - In DONE for a read: the done pulse is suppressed.
  - WRITE, or DONE for a store: unaffected.
  - In IDLE: the request is not granted this cycle.
- Reset mid-operation: immediate return to IDLE. A store may be left partially written; this is accepted.

## Timing
- Reset values: all outputs 0, state IDLE, last_grant=fetch.
- Request first seen high in cycle 0 → first mem_a in cycle 1.
- Read of N bytes: done in cycle N+2 (LW/fetch cycle 6, LB cycle 3).
- Write of N bytes: mem_wr high in cycles 1..N; done in cycle N+1.
- Minimum gap from one done to the next grant: 1 cycle, since DONE ignores requests.
- Requester inputs must be stable from the request cycle until done.

## Configuration
- MEM_CTRL_IO_STALL_EN defined: a store with lsu_addr[17:16]==2'b11 stays in IDLE without a grant while io_buffer_full=1.
  - While stalled, a pending fetch is granted instead.
  - Once granted, the store proceeds regardless of io_buffer_full.
- Undefined: io_buffer_full is ignored.

## Structure
- Shared package (const_def): func3 size/unsigned field positions, and the state encoding localparams.
- One sub-module: mem_rr_arbiter, a 2-way round-robin arbiter. Inputs: two requests, enable (state==IDLE && !flush_input), per-requester mask (IO stall). Outputs: one-hot grant. Holds last_grant internally.
- Byte extraction and extension stay inline.

## Test plan
- LW from 0x100 holding bytes 11 22 33 44, if_req-free → mem_a 0x100..0x103 in cycles 1–4; lsu_done cycle 6; lsu_rdata=0x44332211.
- LB from byte 0x80 → lsu_rdata=0xFFFFFF80. LBU from byte 0x80 → 0x00000080. LH from bytes 0x34 0x92 → 0xFFFF9234.
- SH data 0xAABBCCDD at 0x200 → mem_wr=1 in cycles 1–2, writing 0xDD@0x200 and 0xCC@0x201; done cycle 3; RAM byte 0x202 unchanged.
- if_req and lsu_req both high from reset → LSU granted first; fetch granted in the cycle after lsu_done. Second tie in that order → LSU granted again.
- flush_input in cycle 3 of an LW → no lsu_done. A new if_req granted from IDLE reads the correct word. Flush during an SW → all 4 bytes written, lsu_done asserted.
- With MEM_CTRL_IO_STALL_EN: SB to 0x30000 while io_buffer_full=1 for 10 cycles → mem_wr stays 0 and a concurrent fetch completes. Once full drops → write issued and done 2 cycles after grant.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants for the byte-serial RAM controller.
// Holds the func3 field positions, access sizes, the state encoding and the
// access-size to byte-count helper used by mem_ctrl.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  // func3 layout: [1:0] access size, [2] unsigned load
  localparam int unsigned F3_SIZE_LSB = 0;
  localparam int unsigned F3_SIZE_MSB = 1;
  localparam int unsigned F3_UNS_BIT  = 2;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    WRITE = ST_WRITE,
    DONE  = ST_DONE
  } state_e;

  // Byte count of an access; the unused size code is treated as a word.
  function automatic logic [CNT_W-1:0] num_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  num_bytes = 3'd1;
      SIZE_H:  num_bytes = 3'd2;
      default: num_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: 2-way round-robin arbiter (fetch vs. load/store).
// Ports: clk, rst (sync, active high), en (grant allowed this cycle),
//   req_if/req_lsu requests, mask_if/mask_lsu per-requester block,
//   gnt_if_c/gnt_lsu_c one-hot combinational grant.
// last_grant resets to fetch, so the LSU wins the first tie.
module mem_rr_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_if,
  input  logic req_lsu,
  input  logic mask_if,
  input  logic mask_lsu,
  output logic gnt_if_c,
  output logic gnt_lsu_c
);

  logic last_lsu_q, last_lsu_d;
  logic elig_if, elig_lsu;

  // Grant selection: on a tie, favour whoever was not granted last
  always_comb begin
    elig_if    = en & req_if & ~mask_if;
    elig_lsu   = en & req_lsu & ~mask_lsu;
    gnt_if_c   = 1'b0;
    gnt_lsu_c  = 1'b0;
    last_lsu_d = last_lsu_q;
    if (elig_if && elig_lsu) begin
      if (last_lsu_q) gnt_if_c  = 1'b1;
      else            gnt_lsu_c = 1'b1;
    end else if (elig_if) begin
      gnt_if_c = 1'b1;
    end else if (elig_lsu) begin
      gnt_lsu_c = 1'b1;
    end
    if (gnt_lsu_c)     last_lsu_d = 1'b1;
    else if (gnt_if_c) last_lsu_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) last_lsu_q <= 1'b0;
    else     last_lsu_q <= last_lsu_d;
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial controller for one 8-bit RAM port shared by
// instruction fetch and the load/store unit.
// Ports: clk_in, rst_in (sync active high), flush_input (aborts reads);
//   fetch: if_req/if_addr in, if_done/if_rdata out;
//   lsu: lsu_req/lsu_we/lsu_op/lsu_addr/lsu_wdata in, lsu_done/lsu_rdata out;
//   RAM: mem_din in, mem_dout/mem_a/mem_wr out; io_buffer_full in.
// Optional build macro MEM_CTRL_IO_STALL_EN: holds off stores to the I/O
// window (addr[17:16]==2'b11) while io_buffer_full is set.
// The done pulses are combinational so a flush in DONE can cancel them.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        flush_input,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_op,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic                we_q, we_d;
  logic                sel_lsu_q, sel_lsu_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic [BYTE_W-1:0]   mem_dout_q, mem_dout_d;
  logic                mem_wr_q, mem_wr_d;

  logic                arb_en, mask_lsu, gnt_if, gnt_lsu;
  logic [CNT_W-1:0]    nbytes;
  logic [1:0]          byte_idx;
  logic [DATA_W-1:0]   asm_word;

`ifdef MEM_CTRL_IO_STALL_EN
  assign mask_lsu = lsu_we & (lsu_addr[17:16] == 2'b11) & io_buffer_full;
`else
  logic unused_io_full;
  assign unused_io_full = io_buffer_full;
  assign mask_lsu       = 1'b0;
`endif

  assign arb_en = (state_q == IDLE) && !flush_input;

  mem_rr_arbiter u_arb (
    .clk       (clk_in),
    .rst       (rst_in),
    .en        (arb_en),
    .req_if    (if_req),
    .req_lsu   (lsu_req),
    .mask_if   (1'b0),
    .mask_lsu  (mask_lsu),
    .gnt_if_c  (gnt_if),
    .gnt_lsu_c (gnt_lsu)
  );

  // Next state, byte sequencing and read assembly
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    size_d     = size_q;
    uns_d      = uns_q;
    we_d       = we_q;
    sel_lsu_d  = sel_lsu_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = '0;
    mem_wr_d   = 1'b0;

    nbytes   = num_bytes(size_q);
    // mem_din carries the byte addressed one cycle earlier
    byte_idx = 2'(cnt_q - 3'd1);
    asm_word = rdata_q;
    case (byte_idx)
      2'd0:    asm_word[7:0]   = mem_din;
      2'd1:    asm_word[15:8]  = mem_din;
      2'd2:    asm_word[23:16] = mem_din;
      default: asm_word[31:24] = mem_din;
    endcase

    case (state_q)
      IDLE: begin
        if (gnt_lsu) begin
          sel_lsu_d = 1'b1;
          we_d      = lsu_we;
          size_d    = lsu_op[F3_SIZE_MSB:F3_SIZE_LSB];
          uns_d     = lsu_op[F3_UNS_BIT];
          addr_d    = lsu_addr;
          wdata_d   = lsu_wdata;
          cnt_d     = '0;
          rdata_d   = '0;
          mem_a_d   = lsu_addr;
          if (lsu_we) begin
            mem_wr_d   = 1'b1;
            mem_dout_d = lsu_wdata[7:0];
            state_d    = WRITE;
          end else begin
            state_d = READ;
          end
        end else if (gnt_if) begin
          sel_lsu_d = 1'b0;
          we_d      = 1'b0;
          size_d    = SIZE_W;
          uns_d     = 1'b1;
          addr_d    = if_addr;
          cnt_d     = '0;
          rdata_d   = '0;
          mem_a_d   = if_addr;
          state_d   = READ;
        end
      end
      READ: begin
        if (flush_input) begin
          state_d = IDLE;
        end else begin
          if (cnt_q != 3'd0) rdata_d = asm_word;
          if (cnt_q == nbytes) begin
            // Sign-extend sub-word signed loads; words and unsigned zero-fill
            case (size_q)
              SIZE_B:  rdata_d = {{24{asm_word[7] & ~uns_q}}, asm_word[7:0]};
              SIZE_H:  rdata_d = {{16{asm_word[15] & ~uns_q}}, asm_word[15:0]};
              default: rdata_d = asm_word;
            endcase
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 3'd1;
            mem_a_d = addr_q + ADDR_W'(cnt_d);
          end
        end
      end
      WRITE: begin
        if (cnt_q == nbytes - 3'd1) begin
          state_d = DONE;
        end else begin
          cnt_d    = cnt_q + 3'd1;
          mem_a_d  = addr_q + ADDR_W'(cnt_d);
          mem_wr_d = 1'b1;
          case (cnt_d[1:0])
            2'd0:    mem_dout_d = wdata_q[7:0];
            2'd1:    mem_dout_d = wdata_q[15:8];
            2'd2:    mem_dout_d = wdata_q[23:16];
            default: mem_dout_d = wdata_q[31:24];
          endcase
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_lsu_q  <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      we_q       <= we_d;
      sel_lsu_q  <= sel_lsu_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  // A flush cancels a pending read completion; stores always report done
  assign if_done   = (state_q == DONE) && !sel_lsu_q && !flush_input;
  assign lsu_done  = (state_q == DONE) && sel_lsu_q && (we_q || !flush_input);
  assign if_rdata  = rdata_q;
  assign lsu_rdata = rdata_q;
  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a byte-wide RAM model and a
// scoreboard of expected done events (requester, cycle, data).
// Cycle 0 is the cycle in which a request is first presented.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, flush_input;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        lsu_req, lsu_we, lsu_done;
  logic [2:0]  lsu_op;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  logic [7:0]  ram [0:262143];
  logic        pl_we;
  logic [17:0] pl_a;
  logic [7:0]  pl_d;

  typedef struct {
    logic        src;
    logic [31:0] data;
    logic        has_data;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] tr_a [0:63];
  logic        tr_wr [0:63];
  logic [7:0]  tr_dout [0:63];

  always #5 clk_in = ~clk_in;

  mem_ctrl dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .flush_input    (flush_input),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_done        (if_done),
    .if_rdata       (if_rdata),
    .lsu_req        (lsu_req),
    .lsu_we         (lsu_we),
    .lsu_op         (lsu_op),
    .lsu_addr       (lsu_addr),
    .lsu_wdata      (lsu_wdata),
    .lsu_done       (lsu_done),
    .lsu_rdata      (lsu_rdata),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  // RAM: read data appears one cycle after the address
  always @(posedge clk_in) begin
    if (pl_we)       ram[pl_a] <= pl_d;
    else if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    mem_din <= ram[mem_a[17:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [17:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk_in);
  endtask

  task automatic lsu_set(input logic we, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] wd);
    lsu_req = 1'b1; lsu_we = we; lsu_op = op; lsu_addr = a; lsu_wdata = wd;
  endtask

  task automatic fetch_set(input logic [31:0] a);
    if_req = 1'b1; if_addr = a;
  endtask

  task automatic expect_done(input logic src, input logic [31:0] d, input logic hd,
                             input int cyc, input string tag);
    exp_t e;
    e.src = src; e.data = d; e.has_data = hd; e.cyc = cyc; e.tag = tag;
    sb.push_back(e);
  endtask

  // Step cycles after cycle 0 until every expected done is seen or budget runs out
  task automatic run(input int budget, input int flush_on, input int full_off);
    int c = 0;
    while (sb.size() > 0 && c < budget) begin
      @(negedge clk_in);
      c++;
      if (c < 64) begin
        tr_a[c] = mem_a; tr_wr[c] = mem_wr; tr_dout[c] = mem_dout;
      end
      if (lsu_done || if_done) begin
        exp_t e;
        logic src;
        src = lsu_done;
        e = sb.pop_front();
        chk({e.tag, "_src"}, 32'(src), 32'(e.src));
        chk({e.tag, "_cyc"}, c, e.cyc);
        if (e.has_data) chk({e.tag, "_data"}, src ? lsu_rdata : if_rdata, e.data);
        if (src) lsu_req = 1'b0;
        else     if_req = 1'b0;
        flush_input = 1'b0;
      end
      if (c == flush_on) flush_input = 1'b1;
      if (c == full_off) io_buffer_full = 1'b0;
    end
    if (sb.size() > 0) begin
      chk("timeout", sb.size(), 0);
      sb.delete();
    end
    lsu_req = 1'b0; if_req = 1'b0; flush_input = 1'b0; io_buffer_full = 1'b0;
  endtask

  initial begin
    int ndone;
    logic any_wr;
    rst_in = 1'b1; flush_input = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_op = '0; lsu_addr = '0; lsu_wdata = '0;
    pl_we = 1'b0; pl_a = '0; pl_d = '0;
    @(negedge clk_in);
    @(negedge clk_in);

    // Reset values
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_mem_dout", 32'(mem_dout), 32'h0);
    chk("rst_if_done", 32'(if_done), 32'h0);
    chk("rst_lsu_done", 32'(lsu_done), 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_lsu_rdata", lsu_rdata, 32'h0);

    poke(18'h00100, 8'h11); poke(18'h00101, 8'h22);
    poke(18'h00102, 8'h33); poke(18'h00103, 8'h44);
    poke(18'h00110, 8'h80);
    poke(18'h00120, 8'h34); poke(18'h00121, 8'h92);
    poke(18'h00200, 8'h55); poke(18'h00201, 8'h55);
    poke(18'h00202, 8'h55); poke(18'h00203, 8'h55);
    poke(18'h00300, 8'hDE); poke(18'h00301, 8'hAD);
    poke(18'h00302, 8'hBE); poke(18'h00303, 8'hEF);
    poke(18'h3FFFF, 8'h01); poke(18'h00000, 8'h80);
    pl_we = 1'b0;

    // Tie from reset: LSU first, fetch in the cycle after lsu_done
    lsu_set(1'b0, 3'b010, 32'h100, 32'h0);
    fetch_set(32'h300);
    @(negedge clk_in);
    rst_in = 1'b0;
    expect_done(1'b1, 32'h44332211, 1'b1, 6, "tie1_lw");
    expect_done(1'b0, 32'hEFBEADDE, 1'b1, 13, "tie1_fetch");
    run(40, -1, -1);

    // Second tie: last grant was fetch, so LSU again
    @(negedge clk_in);
    lsu_set(1'b0, 3'b000, 32'h110, 32'h0);
    fetch_set(32'h100);
    expect_done(1'b1, 32'hFFFFFF80, 1'b1, 3, "tie2_lb");
    expect_done(1'b0, 32'h44332211, 1'b1, 10, "tie2_fetch");
    run(40, -1, -1);

    // Standalone LW: address sequence and latency
    @(negedge clk_in);
    lsu_set(1'b0, 3'b010, 32'h100, 32'h0);
    expect_done(1'b1, 32'h44332211, 1'b1, 6, "lw");
    run(20, -1, -1);
    chk("lw_a1", tr_a[1], 32'h100);
    chk("lw_a2", tr_a[2], 32'h101);
    chk("lw_a3", tr_a[3], 32'h102);
    chk("lw_a4", tr_a[4], 32'h103);
    chk("lw_wr", 32'(tr_wr[3]), 32'h0);

    // LBU, LH, LH across the 32-bit address wrap
    @(negedge clk_in);
    lsu_set(1'b0, 3'b100, 32'h110, 32'h0);
    expect_done(1'b1, 32'h00000080, 1'b1, 3, "lbu");
    run(20, -1, -1);
    @(negedge clk_in);
    lsu_set(1'b0, 3'b001, 32'h120, 32'h0);
    expect_done(1'b1, 32'hFFFF9234, 1'b1, 4, "lh");
    run(20, -1, -1);
    @(negedge clk_in);
    lsu_set(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);
    expect_done(1'b1, 32'hFFFF8001, 1'b1, 4, "lh_wrap");
    run(20, -1, -1);
    chk("wrap_a1", tr_a[1], 32'hFFFFFFFF);
    chk("wrap_a2", tr_a[2], 32'h0);

    // SH: two bytes written, neighbour untouched
    @(negedge clk_in);
    lsu_set(1'b1, 3'b001, 32'h200, 32'hAABBCCDD);
    expect_done(1'b1, 32'h0, 1'b0, 3, "sh");
    run(20, -1, -1);
    chk("sh_wr1", 32'(tr_wr[1]), 32'h1);
    chk("sh_a1", tr_a[1], 32'h200);
    chk("sh_d1", 32'(tr_dout[1]), 32'hDD);
    chk("sh_wr2", 32'(tr_wr[2]), 32'h1);
    chk("sh_a2", tr_a[2], 32'h201);
    chk("sh_d2", 32'(tr_dout[2]), 32'hCC);
    chk("sh_wr3", 32'(tr_wr[3]), 32'h0);
    chk("sh_ram200", 32'(ram[18'h200]), 32'hDD);
    chk("sh_ram201", 32'(ram[18'h201]), 32'hCC);
    chk("sh_ram202", 32'(ram[18'h202]), 32'h55);

    // Flush in cycle 3 of an LW: no done, then a fetch reads cleanly
    @(negedge clk_in);
    lsu_set(1'b0, 3'b010, 32'h100, 32'h0);
    ndone = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk_in);
      #1 flush_input = (c == 3);
      @(negedge clk_in);
      ndone += int'(lsu_done);
      if (c == 3) lsu_req = 1'b0;
    end
    flush_input = 1'b0;
    chk("flush_lw_nodone", ndone, 0);
    @(negedge clk_in);
    fetch_set(32'h100);
    expect_done(1'b0, 32'h44332211, 1'b1, 6, "fetch_after_flush");
    run(20, -1, -1);

    // Flush while a read sits in DONE: pulse suppressed
    @(negedge clk_in);
    lsu_set(1'b0, 3'b000, 32'h110, 32'h0);
    ndone = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk_in);
      #1 flush_input = (c == 3);
      @(negedge clk_in);
      ndone += int'(lsu_done);
      if (c == 3) lsu_req = 1'b0;
    end
    flush_input = 1'b0;
    chk("flush_done_nodone", ndone, 0);

    // Flush during SW: store completes and reports done
    @(negedge clk_in);
    lsu_set(1'b1, 3'b010, 32'h400, 32'hCAFEF00D);
    expect_done(1'b1, 32'h0, 1'b0, 5, "sw_flush");
    run(20, 2, -1);
    chk("sw_ram400", 32'(ram[18'h400]), 32'h0D);
    chk("sw_ram401", 32'(ram[18'h401]), 32'hF0);
    chk("sw_ram402", 32'(ram[18'h402]), 32'hFE);
    chk("sw_ram403", 32'(ram[18'h403]), 32'hCA);

`ifdef MEM_CTRL_IO_STALL_EN
    // Stalled I/O store lets a fetch through, then writes once unblocked
    @(negedge clk_in);
    io_buffer_full = 1'b1;
    lsu_set(1'b1, 3'b000, 32'h30000, 32'h0000005A);
    fetch_set(32'h100);
    expect_done(1'b0, 32'h44332211, 1'b1, 6, "stall_fetch");
    expect_done(1'b1, 32'h0, 1'b0, 11, "stall_sb");
    run(30, -1, 9);
    any_wr = 1'b0;
    for (int c = 1; c <= 9; c++) any_wr |= tr_wr[c];
    chk("stall_no_wr", 32'(any_wr), 32'h0);
    chk("stall_wr", 32'(tr_wr[10]), 32'h1);
    chk("stall_a", tr_a[10], 32'h30000);
    chk("stall_ram", 32'(ram[18'h30000]), 32'h5A);
`else
    // io_buffer_full has no effect on an I/O store
    @(negedge clk_in);
    io_buffer_full = 1'b1;
    lsu_set(1'b1, 3'b000, 32'h30000, 32'h0000005A);
    expect_done(1'b1, 32'h0, 1'b0, 2, "io_sb");
    run(20, -1, -1);
    any_wr = tr_wr[1];
    chk("io_wr1", 32'(any_wr), 32'h1);
    chk("io_ram", 32'(ram[18'h30000]), 32'h5A);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
